instr_mem_unit: RTL and testbench
=================================

// Module: instr_mem_unit
// PURPOSE
//  Parametrised instruction memory and fetch stage feeding mips_processor.instr from pc_out.
//  Loaded after reset through a valid/ready word-stream port, then serves registered
//  fetches at byte-addressed PCs. Adds stall, misalignment/range fault, and NOP substitution.
// PARAMETERS
//  DATA_W   32            instruction word width
//  DEPTH    64            number of words; power of two, >=4
//  ADDR_W   32            PC width (byte address)
//  NOP_WORD 32'h00000000  word driven on fault, during load, and after reset
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  ld_valid     in   1       load word offered
//  ld_ready     out  1       load word accepted when ld_valid&&ld_ready
//  ld_data      in   DATA_W  load word, written to index ld_ptr
//  ld_last      in   1       final load word; ends load phase
//  mem_ready    out  1       1 = RUN state (program loaded)
//  pc           in   ADDR_W  fetch byte address
//  fetch_en     in   1       0 = stall: hold outputs
//  instr        out  DATA_W  fetched instruction (registered)
//  instr_valid  out  1       instr holds a fetch result
//  fault        out  1       last fetch misaligned or out of range
// BEHAVIOUR
//  - Reset (async assert, sync release): state=LOAD, ld_ptr=0, instr=NOP_WORD, instr_valid=0,
//    fault=0, mem_ready=0, ld_ready=0. Array contents are not reset.
//  - LOAD: ld_ready=1. Each handshake writes mem[ld_ptr]<=ld_data, ld_ptr++.
//    Handshake with ld_last=1, or the handshake at ld_ptr==DEPTH-1, -> RUN next edge.
//    Words never written keep prior/unknown contents. pc/fetch_en ignored; instr=NOP_WORD, valid=0.
//  - RUN: ld_ready=0; ld_valid ignored; mem_ready=1.
//  - Fetch: latency 1. Edge with fetch_en=1: idx=pc>>2.
//    pc[1:0]!=0 or idx>=DEPTH -> instr<=NOP_WORD, fault<=1; else instr<=mem[idx], fault<=0.
//    instr_valid<=1. fault is per-fetch, not sticky.
//  - fetch_en=0 in RUN: instr, fault, instr_valid hold their values.
//  - Compare idx against DEPTH at full ADDR_W-2 width; upper PC bits count toward out-of-range.
//  - Reset mid-load: restart at ld_ptr=0. Words already written remain.
//  - Load and fetch never coincide: fetch is only active in RUN.
// CONFIGURATION
//  Macro IMEM_FETCH_CNT_EN:
//   defined: extra port fetch_cnt out 32. Reset to 0; +1 per RUN edge with fetch_en=1,
//            including faulting fetches; wraps 0xFFFFFFFF->0.
//   undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package imem_pkg: state encoding (S_LOAD=1'b0, S_RUN=1'b1), default NOP constant,
//    clog2-based index-width localparam helper.
//  - Sub-module imem_array: DEPTH x DATA_W, one sync write port, one registered read port.
//  - Top holds the FSM, ld_ptr, fault/NOP mux, hold logic, and optional counter.
// TESTING (DEPTH=64 unless stated)
//  1 Load 0x01098020,0x014B8822,0x018D9024 (last) -> mem_ready=1 one edge after the last word;
//    fetch pc=0,4,8 -> instr=those words one edge later, fault=0.
//  2 RUN, pc=2 -> instr=NOP_WORD, fault=1, instr_valid=1; next pc=4 -> fault=0.
//  3 RUN, pc=256 (idx 64) and pc=0x80000000 -> NOP_WORD, fault=1.
//  4 Fetch pc=4, then fetch_en=0 for 3 cycles with pc=8 -> instr stays 0x014B8822.
//  5 Load 2 words, assert rst_n=0 mid-stream -> outputs at reset values, ld_ptr restarts at 0;
//    reload 1 word (last) and fetch pc=0 -> new word.
//  6 DEPTH=4: stream 4 words, ld_last=0 -> RUN after 4th; 5th ld_valid sees ld_ready=0.
//    With IMEM_FETCH_CNT_EN: 5 fetches incl. 1 fault -> fetch_cnt=5.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory unit: state encoding,
// default NOP word and the index-width helper.
package imem_pkg;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } imem_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered
// read port. Contents and read register are deliberately not reset.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem_unit.sv
// Instruction memory and fetch stage: streamed load phase, then registered fetches.
// Optional fetch counter port enabled by defining IMEM_FETCH_CNT_EN.
module instr_mem_unit
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault
`ifdef IMEM_FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam int IDX_W = idx_width(DEPTH);

  imem_state_t       state_q, state_d;
  logic [IDX_W-1:0]  ld_ptr;
  logic              active_q;
  logic [ADDR_W-3:0] pc_idx;
  logic              bad_addr;
  logic              ld_fire;
  logic              fetch_go;
  logic [DATA_W-1:0] rd_data;

  assign pc_idx   = pc[ADDR_W-1:2];
  assign bad_addr = (pc[1:0] != 2'b00) || (pc_idx >= (ADDR_W-2)'(DEPTH));
  assign ld_fire  = ld_valid && ld_ready;
  assign fetch_go = (state_q == S_RUN) && fetch_en;

  // active_q keeps ld_ready low while reset is held and for the release edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready = active_q;
        if (ld_fire && (ld_last || ld_ptr == IDX_W'(DEPTH - 1))) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_ready = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr      <= '0;
      fault       <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      if (ld_fire) begin
        ld_ptr <= ld_ptr + 1'b1;
      end
      if (fetch_go) begin
        fault       <= bad_addr;
        instr_valid <= 1'b1;
      end
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (fetch_go) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (ld_fire),
    .wr_idx  (ld_ptr),
    .wr_data (ld_data),
    .rd_en   (fetch_go),
    .rd_idx  (pc_idx[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // The read register holds across stalls; faults and non-fetch states show NOP
  assign instr = (instr_valid && !fault) ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_unit.sv
// Directed bench for instr_mem_unit: a DEPTH=64 instance and a DEPTH=4 instance.
// Checks the fetch counter too when IMEM_FETCH_CNT_EN is defined.
module tb_instr_mem_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic        a_rst_n, a_ld_valid, a_ld_ready, a_ld_last, a_mem_ready;
  logic        a_fetch_en, a_instr_valid, a_fault;
  logic [31:0] a_ld_data, a_pc, a_instr;
  logic        b_rst_n, b_ld_valid, b_ld_ready, b_ld_last, b_mem_ready;
  logic        b_fetch_en, b_instr_valid, b_fault;
  logic [31:0] b_ld_data, b_pc, b_instr;
`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] a_fetch_cnt, b_fetch_cnt;
`endif

  instr_mem_unit #(.DEPTH(64)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .ld_valid(a_ld_valid), .ld_ready(a_ld_ready),
    .ld_data(a_ld_data), .ld_last(a_ld_last), .mem_ready(a_mem_ready),
    .pc(a_pc), .fetch_en(a_fetch_en), .instr(a_instr),
    .instr_valid(a_instr_valid), .fault(a_fault)
`ifdef IMEM_FETCH_CNT_EN
    , .fetch_cnt(a_fetch_cnt)
`endif
  );

  instr_mem_unit #(.DEPTH(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .ld_data(b_ld_data), .ld_last(b_ld_last), .mem_ready(b_mem_ready),
    .pc(b_pc), .fetch_en(b_fetch_en), .instr(b_instr),
    .instr_valid(b_instr_valid), .fault(b_fault)
`ifdef IMEM_FETCH_CNT_EN
    , .fetch_cnt(b_fetch_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus on the selected instance; sampling point is #1 after the edge
  task automatic applyStimulus(input bit use_b, input logic valid, input logic [31:0] data,
                               input logic last, input logic fetch, input logic [31:0] pc_v);
    if (use_b) begin
      b_ld_valid = valid; b_ld_data = data; b_ld_last = last; b_fetch_en = fetch; b_pc = pc_v;
    end else begin
      a_ld_valid = valid; a_ld_data = data; a_ld_last = last; a_fetch_en = fetch; a_pc = pc_v;
    end
    @(posedge clk);
    #1;
    a_ld_valid = 1'b0; a_ld_last = 1'b0; a_fetch_en = 1'b0;
    b_ld_valid = 1'b0; b_ld_last = 1'b0; b_fetch_en = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_ld_valid = 1'b0; a_ld_data = '0; a_ld_last = 1'b0;
    a_fetch_en = 1'b0; a_pc = '0;
    b_rst_n = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0; b_ld_last = 1'b0;
    b_fetch_en = 1'b0; b_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_ready", {31'd0, a_mem_ready}, 32'd0);
    checkOutput("rst_ld_ready", {31'd0, a_ld_ready}, 32'd0);
    checkOutput("rst_instr", a_instr, NOP);
    checkOutput("rst_valid", {31'd0, a_instr_valid}, 32'd0);
    checkOutput("rst_fault", {31'd0, a_fault}, 32'd0);
`ifdef IMEM_FETCH_CNT_EN
    checkOutput("rst_fetch_cnt", a_fetch_cnt, 32'd0);
`endif
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("load_ld_ready", {31'd0, a_ld_ready}, 32'd1);

    // Test 1: load three words, fetch them back
    applyStimulus(0, 1, 32'h0109_8020, 0, 0, 0);
    applyStimulus(0, 1, 32'h014B_8822, 0, 1, 32'd4);
    checkOutput("load_instr_nop", a_instr, NOP);
    checkOutput("load_mem_ready0", {31'd0, a_mem_ready}, 32'd0);
    applyStimulus(0, 1, 32'h018D_9024, 1, 0, 0);
    checkOutput("run_mem_ready", {31'd0, a_mem_ready}, 32'd1);
    checkOutput("run_ld_ready", {31'd0, a_ld_ready}, 32'd0);
    checkOutput("load_valid0", {31'd0, a_instr_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'd0);
    checkOutput("fetch0", a_instr, 32'h0109_8020);
    checkOutput("fetch0_fault", {31'd0, a_fault}, 32'd0);
    checkOutput("fetch0_valid", {31'd0, a_instr_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'd4);
    checkOutput("fetch4", a_instr, 32'h014B_8822);
    applyStimulus(0, 0, 0, 0, 1, 32'd8);
    checkOutput("fetch8", a_instr, 32'h018D_9024);
    checkOutput("fetch8_fault", {31'd0, a_fault}, 32'd0);

    // Test 2: misaligned then aligned
    applyStimulus(0, 0, 0, 0, 1, 32'd2);
    checkOutput("misalign_instr", a_instr, NOP);
    checkOutput("misalign_fault", {31'd0, a_fault}, 32'd1);
    checkOutput("misalign_valid", {31'd0, a_instr_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'd4);
    checkOutput("realign_fault", {31'd0, a_fault}, 32'd0);
    checkOutput("realign_instr", a_instr, 32'h014B_8822);

    // Test 3: out of range
    applyStimulus(0, 0, 0, 0, 1, 32'd256);
    checkOutput("oor256_instr", a_instr, NOP);
    checkOutput("oor256_fault", {31'd0, a_fault}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'h8000_0000);
    checkOutput("oor_hi_instr", a_instr, NOP);
    checkOutput("oor_hi_fault", {31'd0, a_fault}, 32'd1);

    // Test 4: stall holds outputs
    applyStimulus(0, 0, 0, 0, 1, 32'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'd8);
      checkOutput("stall_instr", a_instr, 32'h014B_8822);
      checkOutput("stall_fault", {31'd0, a_fault}, 32'd0);
    end

    // Test 5: reset in the middle of a load
    a_rst_n = 1'b0;
    #1;
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 32'hAAAA_0001, 0, 0, 0);
    applyStimulus(0, 1, 32'hAAAA_0002, 0, 0, 0);
    a_rst_n = 1'b0;
    #1;
    checkOutput("midrst_mem_ready", {31'd0, a_mem_ready}, 32'd0);
    checkOutput("midrst_ld_ready", {31'd0, a_ld_ready}, 32'd0);
    checkOutput("midrst_instr", a_instr, NOP);
    checkOutput("midrst_valid", {31'd0, a_instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 32'h1234_5678, 1, 0, 0);
    checkOutput("reload_mem_ready", {31'd0, a_mem_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'd0);
    checkOutput("reload_fetch0", a_instr, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 1, 32'd4);
    checkOutput("reload_keep1", a_instr, 32'hAAAA_0002);

    // Test 6: DEPTH=4 fills without ld_last
    applyStimulus(1, 1, 32'h0000_0011, 0, 0, 0);
    applyStimulus(1, 1, 32'h0000_0022, 0, 0, 0);
    applyStimulus(1, 1, 32'h0000_0033, 0, 0, 0);
    checkOutput("d4_not_ready", {31'd0, b_mem_ready}, 32'd0);
    applyStimulus(1, 1, 32'h0000_0044, 0, 0, 0);
    checkOutput("d4_mem_ready", {31'd0, b_mem_ready}, 32'd1);
    b_ld_valid = 1'b1;
    b_ld_data  = 32'h0000_0055;
    #1;
    checkOutput("d4_fifth_ready", {31'd0, b_ld_ready}, 32'd0);
    @(posedge clk);
    #1;
    b_ld_valid = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 32'd0);
    checkOutput("d4_fetch0", b_instr, 32'h0000_0011);
    applyStimulus(1, 0, 0, 0, 1, 32'd4);
    checkOutput("d4_fetch4", b_instr, 32'h0000_0022);
    applyStimulus(1, 0, 0, 0, 1, 32'd8);
    checkOutput("d4_fetch8", b_instr, 32'h0000_0033);
    applyStimulus(1, 0, 0, 0, 1, 32'd12);
    checkOutput("d4_fetch12", b_instr, 32'h0000_0044);
    applyStimulus(1, 0, 0, 0, 1, 32'd16);
    checkOutput("d4_oor_instr", b_instr, NOP);
    checkOutput("d4_oor_fault", {31'd0, b_fault}, 32'd1);
`ifdef IMEM_FETCH_CNT_EN
    checkOutput("d4_fetch_cnt", b_fetch_cnt, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
